nco_sweep_ctrl: RTL and testbench

Sequencer that generates the 32-bit frequency control word driving the NCO tuning input (NCO_in of the top-level NCO). It steps the word linearly from a programmed start value by a signed increment, holding each word for a programmed dwell count. This produces stepped chirps and frequency sweeps, either one-shot or looping. Configuration is latched through a valid/ready handshake, and the sweep is controlled by start and abort pulses.

---
 rtl/nco_sweep_ctrl.sv | 140 ++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Stepped-frequency sweep sequencer for the NCO tuning input: walks a tuning word
// from a start value by a signed increment, holding each word for a dwell count.
module nco_sweep_ctrl #(
  parameter int FCW_W      = 32,
  parameter int STEP_CNT_W = 12,
  parameter int DWELL_W    = 16
) (
  input  logic                  clk_top,
  input  logic                  rst_top,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [FCW_W-1:0]      cfg_start_fcw,
  input  logic [FCW_W-1:0]      cfg_step_fcw,
  input  logic [STEP_CNT_W-1:0] cfg_num_steps,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  input  logic                  cfg_loop,
  input  logic                  start,
  input  logic                  abort,
  output logic [FCW_W-1:0]      nco_fcw,
  output logic                  busy,
  output logic                  done,
  output logic [STEP_CNT_W-1:0] step_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [FCW_W-1:0]        start_r, start_nxt;
  logic signed [FCW_W-1:0] step_r, step_nxt;
  logic [STEP_CNT_W-1:0]   num_r, num_nxt;
  logic [DWELL_W-1:0]      dwell_r, dwell_nxt;
  logic                    loop_r, loop_nxt;
  logic [DWELL_W-1:0]      dwell_cnt, dwell_cnt_nxt;
  logic [FCW_W-1:0]        fcw_nxt;
  logic [STEP_CNT_W-1:0]   idx_nxt;
  logic                    busy_nxt, done_nxt;
  logic                    cfg_take;

  // Zero-valued step count and dwell both behave as one.
  function automatic logic [STEP_CNT_W-1:0] last_index(input logic [STEP_CNT_W-1:0] n);
    return (n == '0) ? '0 : n - 1'b1;
  endfunction

  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign cfg_ready = (state != RUN);
  assign cfg_take  = cfg_valid && cfg_ready;

  always_comb begin
    state_nxt     = state;
    start_nxt     = start_r;
    step_nxt      = step_r;
    num_nxt       = num_r;
    dwell_nxt     = dwell_r;
    loop_nxt      = loop_r;
    dwell_cnt_nxt = dwell_cnt;
    fcw_nxt       = nco_fcw;
    idx_nxt       = step_idx;
    busy_nxt      = busy;
    done_nxt      = 1'b0;

    // A start in the same cycle as an accepted config uses the new fields.
    if (cfg_take) begin
      start_nxt = cfg_start_fcw;
      step_nxt  = cfg_step_fcw;
      num_nxt   = cfg_num_steps;
      dwell_nxt = cfg_dwell;
      loop_nxt  = cfg_loop;
    end

    if (abort) begin
      state_nxt     = IDLE;
      fcw_nxt       = '0;
      idx_nxt       = '0;
      dwell_cnt_nxt = '0;
      busy_nxt      = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt     = RUN;
            busy_nxt      = 1'b1;
            fcw_nxt       = start_nxt;
            idx_nxt       = '0;
            dwell_cnt_nxt = dwell_reload(dwell_nxt);
          end
        end
        RUN: begin
          if (dwell_cnt != '0) begin
            dwell_cnt_nxt = dwell_cnt - 1'b1;
          end else if (step_idx < last_index(num_r)) begin
            fcw_nxt       = $signed(nco_fcw) + step_r;
            idx_nxt       = step_idx + 1'b1;
            dwell_cnt_nxt = dwell_reload(dwell_r);
          end else if (loop_r) begin
            fcw_nxt       = start_r;
            idx_nxt       = '0;
            dwell_cnt_nxt = dwell_reload(dwell_r);
          end else begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_top) begin
    if (rst_top) begin
      state     <= IDLE;
      start_r   <= '0;
      step_r    <= '0;
      num_r     <= '0;
      dwell_r   <= '0;
      loop_r    <= 1'b0;
      dwell_cnt <= '0;
      nco_fcw   <= '0;
      step_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      start_r   <= start_nxt;
      step_r    <= step_nxt;
      num_r     <= num_nxt;
      dwell_r   <= dwell_nxt;
      loop_r    <= loop_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      nco_fcw   <= fcw_nxt;
      step_idx  <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: each scenario queues the per-cycle
// outputs it expects, then pops and compares them as the sweep runs.
module tb_nco_sweep_ctrl;

  logic        clk_top = 1'b0;
  logic        rst_top;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_start_fcw;
  logic [31:0] cfg_step_fcw;
  logic [11:0] cfg_num_steps;
  logic [15:0] cfg_dwell;
  logic        cfg_loop;
  logic        start;
  logic        abort;
  logic [31:0] nco_fcw;
  logic        busy;
  logic        done;
  logic [11:0] step_idx;

  typedef struct packed {
    logic [31:0] fcw;
    logic [11:0] idx;
    logic        busy;
    logic        done;
    logic        ready;
  } exp_t;

  exp_t sb[$];
  exp_t e, o;
  int   n_checks = 0;
  int   n_fail   = 0;

  nco_sweep_ctrl dut (
    .clk_top(clk_top), .rst_top(rst_top),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_fcw(cfg_start_fcw), .cfg_step_fcw(cfg_step_fcw),
    .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
    .start(start), .abort(abort),
    .nco_fcw(nco_fcw), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 clk_top = ~clk_top;

  task automatic set_cfg(input logic [31:0] s, input logic [31:0] st,
                         input logic [11:0] n, input logic [15:0] d, input logic l);
    cfg_start_fcw = s;
    cfg_step_fcw  = st;
    cfg_num_steps = n;
    cfg_dwell     = d;
    cfg_loop      = l;
  endtask

  task automatic push(input logic [31:0] f, input logic [11:0] i,
                      input logic b, input logic dn, input logic r);
    exp_t x;
    x.fcw = f; x.idx = i; x.busy = b; x.done = dn; x.ready = r;
    sb.push_back(x);
  endtask

  task automatic push_oneshot(input logic [31:0] s, input logic [31:0] st,
                              input int n, input int d);
    logic [31:0] w;
    int nn, dd;
    w  = s;
    nn = (n == 0) ? 1 : n;
    dd = (d == 0) ? 1 : d;
    for (int k = 0; k < nn; k++) begin
      for (int c = 0; c < dd; c++) push(w, 12'(k), 1'b1, 1'b0, 1'b0);
      if (k < nn - 1) w = w + st;
    end
    push(w, 12'(nn - 1), 1'b0, 1'b1, 1'b1);
    push(w, 12'(nn - 1), 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_loop(input logic [31:0] s, input logic [31:0] st,
                           input int n, input int d, input int cycles);
    logic [31:0] w;
    int k, c;
    w = s; k = 0; c = 0;
    for (int t = 0; t < cycles; t++) begin
      push(w, 12'(k), 1'b1, 1'b0, 1'b0);
      c++;
      if (c == d) begin
        c = 0;
        if (k == n - 1) begin k = 0; w = s; end
        else begin k++; w = w + st; end
      end
    end
  endtask

  task automatic test_reset();
    rst_top = 1'b1; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(32'hFFFF_FFFF, 32'hFFFF_FFFF, 12'hFFF, 16'hFFFF, 1'b1);
    repeat (3) @(posedge clk_top);
    #1;
    push(32'h0, 12'h0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    o = {nco_fcw, step_idx, busy, done, cfg_ready};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", o, e);
    end
    rst_top = 1'b0;
  endtask

  task automatic test_single_step();
    set_cfg(32'h0100_0000, 32'h0010_0000, 12'd4, 16'd3, 1'b0);
    cfg_valid = 1'b1; start = 1'b1;
    push_oneshot(32'h0100_0000, 32'h0010_0000, 4, 3);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin start = 1'b0; cfg_valid = 1'b0; end
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL single_step cyc %0d: got fcw=%h idx=%0d busy=%b done=%b rdy=%b want fcw=%h idx=%0d busy=%b done=%b rdy=%b",
                 i, o.fcw, o.idx, o.busy, o.done, o.ready, e.fcw, e.idx, e.busy, e.done, e.ready);
      end
    end
  endtask

  task automatic test_down_wrap();
    set_cfg(32'h0000_0010, 32'hFFFF_FFF0, 12'd3, 16'd1, 1'b0);
    cfg_valid = 1'b1; start = 1'b1;
    push(32'h0000_0010, 12'd0, 1'b1, 1'b0, 1'b0);
    push(32'h0000_0000, 12'd1, 1'b1, 1'b0, 1'b0);
    push(32'hFFFF_FFF0, 12'd2, 1'b1, 1'b0, 1'b0);
    push(32'hFFFF_FFF0, 12'd2, 1'b0, 1'b1, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin start = 1'b0; cfg_valid = 1'b0; end
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL down_wrap cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_loop();
    set_cfg(32'h2000_0000, 32'h0000_1000, 12'd2, 16'd2, 1'b1);
    cfg_valid = 1'b1; start = 1'b1;
    push_loop(32'h2000_0000, 32'h0000_1000, 2, 2, 20);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin start = 1'b0; cfg_valid = 1'b0; end
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL loop cyc %0d: got %h want %h", i, o, e);
      end
    end
    abort = 1'b1;
    push(32'h0, 12'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk_top); #1;
    abort = 1'b0;
    e = sb.pop_front();
    o = {nco_fcw, step_idx, busy, done, cfg_ready};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL loop_abort: got %h want %h", o, e);
    end
  endtask

  task automatic test_zero_cfg();
    set_cfg(32'h0000_0005, 32'h0000_0001, 12'd0, 16'd0, 1'b0);
    cfg_valid = 1'b1; start = 1'b1;
    push_oneshot(32'h0000_0005, 32'h0000_0001, 0, 0);
    push(32'h0000_0005, 12'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin start = 1'b0; cfg_valid = 1'b0; end
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL zero_cfg cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_abort();
    set_cfg(32'h0100_0000, 32'h0010_0000, 12'd4, 16'd3, 1'b0);
    cfg_valid = 1'b1; start = 1'b1;
    push_oneshot(32'h0100_0000, 32'h0010_0000, 4, 3);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin start = 1'b0; cfg_valid = 1'b0; end
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_pre cyc %0d: got %h want %h", i, o, e);
      end
    end
    sb.delete();
    abort = 1'b1; start = 1'b1;
    push(32'h0, 12'h0, 1'b0, 1'b0, 1'b1);
    push(32'h0, 12'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      abort = 1'b0; start = 1'b0;
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_idle cyc %0d: got %h want %h", i, o, e);
      end
    end
    start = 1'b1;
    set_cfg(32'h0, 32'h0, 12'd0, 16'd0, 1'b0);
    push_oneshot(32'h0100_0000, 32'h0010_0000, 4, 3);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) start = 1'b0;
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_replay cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_handshake();
    start = 1'b1;
    push_oneshot(32'h0100_0000, 32'h0010_0000, 4, 3);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin
        start = 1'b0;
        set_cfg(32'hDEAD_0000, 32'h0000_0001, 12'd1, 16'd1, 1'b1);
        cfg_valid = 1'b1;
      end
      if (i == 10) cfg_valid = 1'b0;
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL handshake_run cyc %0d: got %h want %h", i, o, e);
      end
    end
    set_cfg(32'h7000_0000, 32'h0000_0001, 12'd2, 16'd1, 1'b0);
    cfg_valid = 1'b1; start = 1'b1;
    push_oneshot(32'h7000_0000, 32'h0000_0001, 2, 1);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin start = 1'b0; cfg_valid = 1'b0; end
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL handshake_done cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    set_cfg(32'h3000_0000, 32'h0000_0100, 12'd3, 16'd2, 1'b1);
    cfg_valid = 1'b1; start = 1'b1;
    push_loop(32'h3000_0000, 32'h0000_0100, 3, 2, 3);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) begin start = 1'b0; cfg_valid = 1'b0; end
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_run cyc %0d: got %h want %h", i, o, e);
      end
    end
    rst_top = 1'b1;
    @(posedge clk_top); #1;
    rst_top = 1'b0;
    push(32'h0, 12'h0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();
    o = {nco_fcw, step_idx, busy, done, cfg_ready};
    n_checks++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want %h", o, e);
    end
    // Cfg registers were cleared, so a bare start runs a single zero word.
    start = 1'b1;
    push_oneshot(32'h0, 32'h0, 0, 0);
    for (int i = 0; sb.size() > 0; i++) begin
      @(posedge clk_top); #1;
      if (i == 0) start = 1'b0;
      e = sb.pop_front();
      o = {nco_fcw, step_idx, busy, done, cfg_ready};
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_mid_cfg cyc %0d: got %h want %h", i, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_down_wrap();
    test_loop();
    test_zero_cfg();
    test_abort();
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
